pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register: the generalised successor to the fixed-width stall/flush inter-stage registers. It carries a CTRL_W-bit control field and a DATA_W-bit data field between two pipeline stages using a valid/ready handshake. An optional one-entry skid buffer registers the stall path so the upstream ready does not depend combinationally on the downstream ready. Control bits are masked to zero whenever the stage holds a bubble, and a saturating counter records upstream stall cycles.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/sat_counter.sv | 19 +
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and default stage widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // DE: operands, immediate, PC+8 and register indices; EM/MW: ALU result, store data, rd.
    localparam int unsigned DE_DATA_W = 160;
    localparam int unsigned DE_CTRL_W = 10;
    localparam int unsigned EM_DATA_W = 101;
    localparam int unsigned EM_CTRL_W = 4;
    localparam int unsigned MW_DATA_W = 101;
    localparam int unsigned MW_CTRL_W = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional one-entry skid buffer,
// bubble-masked control field and a saturating upstream stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DE_DATA_W,
    parameter int unsigned CTRL_W = DE_CTRL_W,
    parameter int unsigned SKID   = 1,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [STAT_W-1:0] stall_cnt
);

    pipe_state_e       state;
    pipe_state_e       stateNext;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] skidCtrl;
    logic [DATA_W-1:0] skidData;
    logic              accept;
    logic              pop;
    logic              loadMainIn;
    logic              loadMainSkid;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and main-register load selects; flush empties without touching data.
    always_comb begin
        stateNext    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    stateNext  = ONE;
                    loadMainIn = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    loadMainIn = 1'b1;
                end else if (accept) begin
                    stateNext = (SKID != 0) ? FULL : ONE;
                end else if (pop) begin
                    stateNext = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    stateNext    = ONE;
                    loadMainSkid = 1'b1;
                end
            end
            default: stateNext = EMPTY;
        endcase
        if (flush) begin
            stateNext    = EMPTY;
            loadMainIn   = 1'b0;
            loadMainSkid = 1'b0;
        end
    end

    // Head-of-stage register presented downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            mainCtrl <= '0;
            mainData <= '0;
        end else if (loadMainIn) begin
            mainCtrl <= in_ctrl;
            mainData <= in_data;
        end else if (loadMainSkid) begin
            mainCtrl <= skidCtrl;
            mainData <= skidData;
        end
    end

    generate
        if (SKID != 0) begin : gSkid
            logic loadSkid;

            // The one entry absorbed while the downstream stall is still propagating upstream.
            assign loadSkid = accept & ~pop & (state == ONE);

            always_ff @(posedge clk) begin
                if (reset) begin
                    skidCtrl <= '0;
                    skidData <= '0;
                end else if (loadSkid) begin
                    skidCtrl <= in_ctrl;
                    skidData <= in_data;
                end
            end

            assign in_ready = (state != FULL) & ~flush & ~reset;
        end else begin : gNoSkid
            assign skidCtrl = '0;
            assign skidData = '0;
            assign in_ready = ~reset & ~flush & (~out_valid | out_ready);
        end
    endgenerate

    assign out_ctrl = out_valid ? mainCtrl : '0;
    assign out_data = mainData;

    sat_counter #(
        .W(STAT_W)
    ) uStallCnt (
        .clk  (clk),
        .clear(reset),
        .inc  (in_valid & ~in_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid, no-skid and narrow-counter instances share one
// stimulus stream and are checked each cycle against queue-based models.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 160;
    localparam int unsigned CW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          flush;
    logic          inValid;
    logic          outReady;
    logic [CW-1:0] inCtrl;
    logic [DW-1:0] inData;

    logic          aInReady, bInReady, cInReady;
    logic          aOutValid, bOutValid, cOutValid;
    logic [CW-1:0] aOutCtrl, bOutCtrl, cOutCtrl;
    logic [DW-1:0] aOutData, bOutData, cOutData;
    logic [15:0]   aStall, bStall;
    logic [3:0]    cStall;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .STAT_W(16)) dutA (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(aInReady),
        .in_ctrl(inCtrl), .in_data(inData), .out_valid(aOutValid), .out_ready(outReady),
        .out_ctrl(aOutCtrl), .out_data(aOutData), .stall_cnt(aStall));

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .STAT_W(16)) dutB (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(bInReady),
        .in_ctrl(inCtrl), .in_data(inData), .out_valid(bOutValid), .out_ready(outReady),
        .out_ctrl(bOutCtrl), .out_data(bOutData), .stall_cnt(bStall));

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .STAT_W(4)) dutC (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(cInReady),
        .in_ctrl(inCtrl), .in_data(inData), .out_valid(cOutValid), .out_ready(outReady),
        .out_ctrl(cOutCtrl), .out_data(cOutData), .stall_cnt(cStall));

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    // Model: a FIFO of capacity 2 (skid) or 1 (no skid), plus the last head data held on bubbles.
    ent_t          qa[$];
    ent_t          qb[$];
    logic [DW-1:0] holdA, holdB;
    int unsigned   cntA, cntB, cntC;
    int            errors = 0;
    int            checks = 0;
    bit            chkEn  = 1'b0;

    function automatic bit rdyA();
        return (reset === 1'b0) && (flush === 1'b0) && (qa.size() < 2);
    endfunction

    function automatic bit rdyB();
        return (reset === 1'b0) && (flush === 1'b0) && ((qb.size() == 0) || (outReady === 1'b1));
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model update on each active edge using the inputs of the cycle just ended.
    always @(posedge clk) begin
        bit ra, rb, accA, accB, popA, popB;
        ent_t e;
        if (reset === 1'b1) begin
            qa.delete();
            qb.delete();
            holdA = '0;
            holdB = '0;
            cntA  = 0;
            cntB  = 0;
            cntC  = 0;
        end else begin
            ra   = rdyA();
            rb   = rdyB();
            e    = '{c: inCtrl, d: inData};
            accA = inValid && ra;
            accB = inValid && rb;
            popA = (qa.size() > 0) && outReady;
            popB = (qb.size() > 0) && outReady;
            if (inValid && !ra) begin
                if (cntA < 65535) cntA++;
                if (cntC < 15) cntC++;
            end
            if (inValid && !rb && cntB < 65535) cntB++;
            if (qa.size() > 0) holdA = qa[0].d;
            if (qb.size() > 0) holdB = qb[0].d;
            if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (popA) void'(qa.pop_front());
                if (accA) qa.push_back(e);
                if (popB) void'(qb.pop_front());
                if (accB) qb.push_back(e);
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chkEn) begin
            chk("a_in_ready", DW'(aInReady), DW'(rdyA()));
            chk("a_out_valid", DW'(aOutValid), DW'(qa.size() > 0));
            chk("a_out_ctrl", DW'(aOutCtrl), (qa.size() > 0) ? DW'(qa[0].c) : DW'(0));
            chk("a_out_data", aOutData, (qa.size() > 0) ? qa[0].d : holdA);
            chk("a_stall_cnt", DW'(aStall), DW'(cntA));
            chk("b_in_ready", DW'(bInReady), DW'(rdyB()));
            chk("b_out_valid", DW'(bOutValid), DW'(qb.size() > 0));
            chk("b_out_ctrl", DW'(bOutCtrl), (qb.size() > 0) ? DW'(qb[0].c) : DW'(0));
            chk("b_out_data", bOutData, (qb.size() > 0) ? qb[0].d : holdB);
            chk("b_stall_cnt", DW'(bStall), DW'(cntB));
            chk("c_in_ready", DW'(cInReady), DW'(rdyA()));
            chk("c_out_data", cOutData, (qa.size() > 0) ? qa[0].d : holdA);
            chk("c_stall_cnt", DW'(cStall), DW'(cntC));
        end
    end

    task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input bit r, input bit f, input bit rs);
        inValid  = v;
        inCtrl   = c;
        inData   = d;
        outReady = r;
        flush    = f;
        reset    = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        // Reset with an offered entry carrying all control bits set.
        drive(1'b1, 10'h3FF, DW'(0), 1'b0, 1'b0, 1'b1);
        #1;
        chk("rst_a_in_ready", DW'(aInReady), DW'(0));
        chk("rst_b_in_ready", DW'(bInReady), DW'(0));
        tick();
        chkEn = 1'b1;
        tick();
        drive(1'b0, '0, DW'(0), 1'b1, 1'b0, 1'b0);
        #1;
        chk("post_rst_out_valid", DW'(aOutValid), DW'(0));
        chk("post_rst_out_ctrl", DW'(aOutCtrl), DW'(0));
        chk("post_rst_stall_cnt", DW'(aStall), DW'(0));
        chk("post_rst_in_ready", DW'(aInReady), DW'(1));

        // Back-to-back streaming with downstream always ready.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, CW'(k), DW'(k), 1'b1, 1'b0, 1'b0);
            tick();
            chk("stream_a_data", aOutData, DW'(k));
            chk("stream_a_valid", DW'(aOutValid), DW'(1));
            chk("stream_b_data", bOutData, DW'(k));
        end

        // Downstream stalls for 3 cycles; entry 5 lands in skid.
        drive(1'b1, CW'(5), DW'(5), 1'b0, 1'b0, 1'b0);
        #1;
        chk("noskid_same_cycle_ready", DW'(bInReady), DW'(0));
        chk("skid_first_stall_ready", DW'(aInReady), DW'(1));
        tick();
        drive(1'b1, CW'(6), DW'(6), 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("skid_stall_cnt", DW'(aStall), DW'(2));
        chk("skid_in_ready", DW'(aInReady), DW'(0));
        drive(1'b1, CW'(6), DW'(6), 1'b1, 1'b0, 1'b0);
        #1;
        chk("drain_4", aOutData, DW'(4));
        tick();
        chk("drain_5", aOutData, DW'(5));
        tick();
        chk("drain_6", aOutData, DW'(6));
        chk("drain_6_valid", DW'(aOutValid), DW'(1));

        // Fill to FULL, then flush with an entry still offered.
        drive(1'b1, CW'(7), DW'(7), 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, CW'(8), DW'(8), 1'b0, 1'b1, 1'b0);
        #1;
        chk("flush_in_ready", DW'(aInReady), DW'(0));
        tick();
        drive(1'b1, 10'h155, DW'(8'hAA), 1'b1, 1'b0, 1'b0);
        #1;
        chk("flush_out_valid", DW'(aOutValid), DW'(0));
        chk("flush_out_ctrl", DW'(aOutCtrl), DW'(0));
        chk("flush_in_ready_after", DW'(aInReady), DW'(1));
        tick();
        chk("after_flush_data", aOutData, DW'(8'hAA));
        chk("after_flush_ctrl", DW'(aOutCtrl), DW'(10'h155));

        // Long stall to saturate the 4-bit counter.
        drive(1'b1, CW'(1), DW'(1), 1'b0, 1'b0, 1'b0);
        repeat (40) tick();
        chk("saturate_15", DW'(cStall), DW'(15));

        // Randomized traffic with occasional flush and reset.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(3) != 0), CW'($urandom), rnd(),
                  ($urandom_range(2) != 0), ($urandom_range(15) == 0),
                  ($urandom_range(199) == 0));
            tick();
        end

        drive(1'b0, '0, DW'(0), 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
